// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef logic port_id_t;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [DMEM_DATA_W-1:0] data;
  } resp_t;

  function automatic port_id_t other_port(input port_id_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory pins of the data-memory arbiter; slave is the arbiter side,
// master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req, p0_lock, p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt, p0_rvalid, p0_err;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req, p1_lock, p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt, p1_rvalid, p1_err;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  p0_req, p0_lock, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_lock, p1_we, p1_addr, p1_wdata,
    input  mem_read_data,
    output p0_gnt, p0_rvalid, p0_err, p0_rdata,
    output p1_gnt, p1_rvalid, p1_err, p1_rdata,
    output mem_addr, mem_write_data, mem_read, mem_write
  );

  modport master (
    output p0_req, p0_lock, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_lock, p1_we, p1_addr, p1_wdata,
    output mem_read_data,
    input  p0_gnt, p0_rvalid, p0_err, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_err, p1_rdata,
    input  mem_addr, mem_write_data, mem_read, mem_write
  );

endinterface

// File: rtl/dmem_rr_picker.sv
// Purpose: round-robin choice between two requesters, restricted to the lock owner when locked.
// Latency: purely combinational.
// Backpressure: a requester that is not picked simply keeps req asserted.
module dmem_rr_picker
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_grant,
  input  logic       locked,
  input  port_id_t   owner,
  output logic       grant_valid,
  output port_id_t   grant_id
);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (locked) begin
      grant_valid = req[owner];
      grant_id    = owner;
    end else if (req == 2'b11) begin
      grant_valid = 1'b1;
      grant_id    = other_port(last_grant);
    end else if (req[1]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end else if (req[0]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose: shares the single-port data memory between core (p0) and debug/DMA (p1), with RMW lock.
// Latency: gnt and memory pins combinational; rvalid/rdata/err registered one cycle after gnt.
// Backpressure: a losing or locked-out port holds req until its gnt; lock is force-released after LOCK_MAX cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LOCK_MAX    = 16
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int                CNT_W     = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_MAX - 1);
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);

  state_e            state, state_d;
  port_id_t          owner, owner_d, last_grant, last_d;
  logic [CNT_W-1:0]  lock_cnt, cnt_d;
  resp_t             rsp0, rsp1;

  logic [1:0]        req;
  logic              gnt_vld, gnt0, gnt1;
  port_id_t          gnt_id;
  logic              sel_we, sel_lock, own_lock, bad, rd_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Gating req with rst_n keeps every gnt and memory strobe low while reset is held.
  assign req = {bus.p1_req, bus.p0_req} & {2{rst_n}};

  dmem_rr_picker u_picker (
    .req         (req),
    .last_grant  (last_grant),
    .locked      (state == LOCKED),
    .owner       (owner),
    .grant_valid (gnt_vld),
    .grant_id    (gnt_id)
  );

  assign sel_we    = gnt_id ? bus.p1_we    : bus.p0_we;
  assign sel_lock  = gnt_id ? bus.p1_lock  : bus.p0_lock;
  assign sel_addr  = gnt_id ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = gnt_id ? bus.p1_wdata : bus.p0_wdata;
  assign own_lock  = owner  ? bus.p1_lock  : bus.p0_lock;

  assign bad   = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[ADDR_W-1:2]} >= DEPTH_LIM);
  assign gnt0  = gnt_vld & ~gnt_id;
  assign gnt1  = gnt_vld &  gnt_id;
  assign rd_ok = gnt_vld & ~sel_we & ~bad;

  assign bus.p0_gnt         = gnt0;
  assign bus.p1_gnt         = gnt1;
  assign bus.mem_addr       = gnt_vld ? sel_addr  : '0;
  assign bus.mem_write_data = gnt_vld ? sel_wdata : '0;
  assign bus.mem_read       = rd_ok;
  assign bus.mem_write      = gnt_vld & sel_we & ~bad;

  always_comb begin
    state_d = state;
    owner_d = owner;
    last_d  = last_grant;
    cnt_d   = lock_cnt;
    if (gnt_vld) last_d = gnt_id;
    case (state)
      IDLE: begin
        if (gnt_vld && sel_lock && !bad) begin
          state_d = LOCKED;
          owner_d = gnt_id;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        cnt_d = lock_cnt + 1'b1;
        if (!own_lock) begin
          state_d = IDLE;
        end else if (lock_cnt == CNT_LAST) begin
          // Forced release: the other port wins the next tie.
          state_d = IDLE;
          last_d  = owner;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      lock_cnt   <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_grant <= last_d;
      lock_cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0 <= '0;
      rsp1 <= '0;
    end else begin
      rsp0.valid <= gnt0;
      rsp0.err   <= gnt0 & bad;
      rsp0.data  <= (gnt0 & rd_ok) ? bus.mem_read_data : '0;
      rsp1.valid <= gnt1;
      rsp1.err   <= gnt1 & bad;
      rsp1.data  <= (gnt1 & rd_ok) ? bus.mem_read_data : '0;
    end
  end

  assign bus.p0_rvalid = rsp0.valid;
  assign bus.p0_err    = rsp0.err;
  assign bus.p0_rdata  = rsp0.data;
  assign bus.p1_rvalid = rsp1.valid;
  assign bus.p1_err    = rsp1.err;
  assign bus.p1_rdata  = rsp1.data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a behavioural model;
// the bench also plays the data memory.
module tb_dmem_arbiter;

  localparam int ADDR_W = 32, DATA_W = 32, DEPTH_WORDS = 256, LOCK_MAX = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_ready = 1'b0;
  int   errors = 0;
  int   checks = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_WORDS(DEPTH_WORDS), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 ^ 32'(i * 7 + 1);
  endfunction

  logic [31:0] tb_mem [DEPTH_WORDS];
  assign bus.mem_read_data = tb_mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH_WORDS; i++) tb_mem[i] <= init_word(i);
    end else if (bus.mem_write) begin
      tb_mem[bus.mem_addr[9:2]] <= bus.mem_write_data;
    end
  end

  // Behavioural arbitration model.
  int m_last, m_owner, m_held;
  bit m_locked;

  function automatic void model_reset();
    m_last = 1; m_owner = 0; m_held = 0; m_locked = 0;
  endfunction

  function automatic int model_grant(input bit r0, input bit r1);
    if (m_locked) return ((m_owner == 0 ? r0 : r1) ? m_owner : -1);
    if (r0 && r1) return 1 - m_last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic void model_advance(input int g, input bit g_lock, input bit g_bad, input bit own_lock);
    if (g >= 0) m_last = g;
    if (m_locked) begin
      m_held++;
      if (!own_lock) m_locked = 0;
      else if (m_held == LOCK_MAX) begin
        m_locked = 0;
        m_last   = m_owner;
      end
    end else if (g >= 0 && g_lock && !g_bad) begin
      m_locked = 1; m_owner = g; m_held = 0;
    end
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH_WORDS);
  endfunction

  task automatic drive(input int p, input logic req, input logic lock, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_lock = lock; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = req; bus.p1_lock = lock; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    drive(0, 1, 0, 0, 32'h10, 0);
    drive(1, 1, 0, 0, 32'h14, 0);
    @(negedge clk);
    checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got=%b exp=0000", {bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write}); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_write_data !== 32'h0) begin
      errors++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", bus.mem_addr, bus.mem_write_data); end
    checks++; if ({bus.p0_rvalid, bus.p0_err, bus.p1_rvalid, bus.p1_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_resp got=%b exp=0000", {bus.p0_rvalid, bus.p0_err, bus.p1_rvalid, bus.p1_err}); end
    checks++; if (bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.p0_rdata, bus.p1_rdata); end
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_write_read();
    drive(0, 1, 0, 1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write} !== 4'b1001) begin
      errors++; $display("FAIL wr_strobes got=%b exp=1001", {bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write}); end
    checks++; if (bus.mem_addr !== 32'h10 || bus.mem_write_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_mem_bus got=%h/%h exp=10/deadbeef", bus.mem_addr, bus.mem_write_data); end
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 32'h10, 0);
    @(negedge clk);
    checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write} !== 4'b1010) begin
      errors++; $display("FAIL rd_strobes got=%b exp=1010", {bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write}); end
    checks++; if ({bus.p0_rvalid, bus.p0_err, bus.p1_rvalid} !== 3'b100 || bus.p0_rdata !== 32'h0) begin
      errors++; $display("FAIL wr_resp got=%b/%h exp=100/0", {bus.p0_rvalid, bus.p0_err, bus.p1_rvalid}, bus.p0_rdata); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++; if ({bus.p0_rvalid, bus.p0_err, bus.p1_rvalid} !== 3'b100 || bus.p0_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_resp got=%b/%h exp=100/deadbeef", {bus.p0_rvalid, bus.p0_err, bus.p1_rvalid}, bus.p0_rdata); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.p0_rvalid !== 1'b0) begin
      errors++; $display("FAIL rvalid_single got=%b exp=0", bus.p0_rvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_alternate();
    do_reset();
    drive(0, 1, 0, 0, 32'h10, 0);
    drive(1, 1, 0, 0, 32'h14, 0);
    for (int i = 0; i < 6; i++) begin
      logic [1:0]  exp_g;
      logic [31:0] got_d, exp_d;
      int          pp;
      if (i == 4) drive(1, 0, 0, 0, 0, 0);
      if (i == 5) idle();
      @(negedge clk);
      if (i < 5) begin
        exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
        checks++; if ({bus.p0_gnt, bus.p1_gnt} !== exp_g) begin
          errors++; $display("FAIL alt_gnt i=%0d got=%b exp=%b", i, {bus.p0_gnt, bus.p1_gnt}, exp_g); end
      end
      if (i > 0) begin
        pp    = (i - 1) % 2;
        exp_g = (pp == 0) ? 2'b10 : 2'b01;
        got_d = (pp == 0) ? bus.p0_rdata : bus.p1_rdata;
        exp_d = (pp == 0) ? 32'hDEAD_BEEF : init_word(5);
        checks++; if ({bus.p0_rvalid, bus.p1_rvalid} !== exp_g || got_d !== exp_d) begin
          errors++; $display("FAIL alt_resp i=%0d got=%b/%h exp=%b/%h", i, {bus.p0_rvalid, bus.p1_rvalid}, got_d, exp_g, exp_d); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_errors();
    drive(1, 1, 0, 0, 32'h12, 0);
    @(negedge clk);
    checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write} !== 4'b0100) begin
      errors++; $display("FAIL mis_strobes got=%b exp=0100", {bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write}); end
    @(posedge clk); #1;
    drive(1, 1, 0, 0, 32'h400, 0);
    @(negedge clk);
    checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write} !== 4'b0100) begin
      errors++; $display("FAIL oor_strobes got=%b exp=0100", {bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write}); end
    checks++; if ({bus.p1_rvalid, bus.p1_err} !== 2'b11 || bus.p1_rdata !== 32'h0) begin
      errors++; $display("FAIL mis_resp got=%b/%h exp=11/0", {bus.p1_rvalid, bus.p1_err}, bus.p1_rdata); end
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 32'h404, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write} !== 4'b1000) begin
      errors++; $display("FAIL badwr_strobes got=%b exp=1000", {bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write}); end
    checks++; if ({bus.p1_rvalid, bus.p1_err} !== 2'b11 || bus.p1_rdata !== 32'h0) begin
      errors++; $display("FAIL oor_resp got=%b/%h exp=11/0", {bus.p1_rvalid, bus.p1_err}, bus.p1_rdata); end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 32'h3FC, 0);
    @(negedge clk);
    checks++; if ({bus.p0_rvalid, bus.p0_err, bus.p1_rvalid} !== 3'b110 || bus.p0_rdata !== 32'h0) begin
      errors++; $display("FAIL badwr_resp got=%b/%h exp=110/0", {bus.p0_rvalid, bus.p0_err, bus.p1_rvalid}, bus.p0_rdata); end
    checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write} !== 4'b0110) begin
      errors++; $display("FAIL lastword_strobes got=%b exp=0110", {bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write}); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++; if ({bus.p1_rvalid, bus.p1_err} !== 2'b10 || bus.p1_rdata !== init_word(255)) begin
      errors++; $display("FAIL lastword_resp got=%b/%h exp=10/%h", {bus.p1_rvalid, bus.p1_err}, bus.p1_rdata, init_word(255)); end
    @(posedge clk); #1;
  endtask

  task automatic test_lock_rmw();
    do_reset();
    drive(0, 1, 1, 0, 32'h20, 0);
    drive(1, 1, 0, 0, 32'h30, 0);
    @(negedge clk);
    checks++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b10) begin
      errors++; $display("FAIL rmw_rd_gnt got=%b exp=10", {bus.p0_gnt, bus.p1_gnt}); end
    @(posedge clk); #1;
    drive(0, 1, 0, 1, 32'h20, 32'h1234);
    @(negedge clk);
    checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.mem_write} !== 3'b101) begin
      errors++; $display("FAIL rmw_wr_gnt got=%b exp=101", {bus.p0_gnt, bus.p1_gnt, bus.mem_write}); end
    checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== init_word(8)) begin
      errors++; $display("FAIL rmw_rd_resp got=%b/%h exp=1/%h", bus.p0_rvalid, bus.p0_rdata, init_word(8)); end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b01) begin
      errors++; $display("FAIL rmw_p1_after got=%b exp=01", {bus.p0_gnt, bus.p1_gnt}); end
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 32'h20, 0);
    @(negedge clk);
    checks++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== init_word(12) || bus.p0_gnt !== 1'b1) begin
      errors++; $display("FAIL rmw_p1_resp got=%b/%h/%b exp=1/%h/1", bus.p1_rvalid, bus.p1_rdata, bus.p0_gnt, init_word(12)); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'h1234) begin
      errors++; $display("FAIL rmw_readback got=%b/%h exp=1/1234", bus.p0_rvalid, bus.p0_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_lock_timeout();
    do_reset();
    drive(0, 1, 1, 0, 32'h40, 0);
    drive(1, 1, 0, 0, 32'h44, 0);
    // Grant at c=0 takes the lock, c=1..16 are the LOCK_MAX locked cycles, p1 wins at c=17.
    for (int c = 0; c < 21; c++) begin
      logic [1:0] exp_g;
      if (c == 18) drive(1, 0, 0, 0, 0, 0);
      if (c == 20) drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      exp_g = (c == 17) ? 2'b01 : ((c == 20) ? 2'b00 : 2'b10);
      checks++; if ({bus.p0_gnt, bus.p1_gnt} !== exp_g) begin
        errors++; $display("FAIL timeout_gnt c=%0d got=%b exp=%b", c, {bus.p0_gnt, bus.p1_gnt}, exp_g); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_pending();
    drive(1, 1, 0, 0, 32'h14, 0);
    @(negedge clk);
    checks++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b01) begin
      errors++; $display("FAIL rstp_gnt got=%b exp=01", {bus.p0_gnt, bus.p1_gnt}); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 1, 0, 0, 32'h10, 0);
    @(negedge clk);
    checks++; if ({bus.p1_rvalid, bus.p1_err, bus.p0_rvalid} !== 3'b000 || bus.p1_rdata !== 32'h0) begin
      errors++; $display("FAIL rstp_resp got=%b/%h exp=000/0", {bus.p1_rvalid, bus.p1_err, bus.p0_rvalid}, bus.p1_rdata); end
    checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write} !== 4'b0000 || bus.mem_addr !== 32'h0) begin
      errors++; $display("FAIL rstp_strobes got=%b/%h exp=0000/0", {bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write}, bus.mem_addr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b10) begin
      errors++; $display("FAIL rstp_tie got=%b exp=10", {bus.p0_gnt, bus.p1_gnt}); end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'hDEAD_BEEF || bus.p1_gnt !== 1'b1) begin
      errors++; $display("FAIL rstp_after got=%b/%h/%b exp=1/deadbeef/1", bus.p0_rvalid, bus.p0_rdata, bus.p1_gnt); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_random();
    bit          pend [2];
    logic        lk [2], we [2], lk_in [2];
    logic [31:0] ad [2], wd [2], erd [2];
    bit          erv [2], eerr [2];
    logic [31:0] exp_mem [DEPTH_WORDS];
    int          g, last_g;
    bit          bad, own;
    for (int i = 0; i < DEPTH_WORDS; i++) exp_mem[i] = init_word(i);
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; erv[p] = 0; eerr[p] = 0; erd[p] = 0;
    end
    last_g = -1;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (last_g == p) pend[p] = 0;
        if (!pend[p] && $urandom_range(0, 3) != 0) begin
          pend[p] = 1;
          lk[p]   = ($urandom_range(0, 3) == 0);
          we[p]   = 1'($urandom_range(0, 1));
          wd[p]   = $urandom;
          case ($urandom_range(0, 9))
            0:       ad[p] = (32'($urandom_range(64, 255)) << 2) | 32'($urandom_range(1, 3));
            1:       ad[p] = 32'($urandom_range(256, 1023)) << 2;
            default: ad[p] = 32'($urandom_range(64, 255)) << 2;
          endcase
        end
        lk_in[p] = pend[p] ? lk[p] : 1'b0;
        drive(p, pend[p], lk_in[p], we[p], ad[p], wd[p]);
      end
      @(negedge clk);
      checks++; if ({bus.p0_rvalid, bus.p0_err, bus.p1_rvalid, bus.p1_err} !== {erv[0], eerr[0], erv[1], eerr[1]}) begin
        errors++; $display("FAIL rnd_resp cyc=%0d got=%b exp=%b", cyc,
          {bus.p0_rvalid, bus.p0_err, bus.p1_rvalid, bus.p1_err}, {erv[0], eerr[0], erv[1], eerr[1]}); end
      checks++; if (bus.p0_rdata !== erd[0] || bus.p1_rdata !== erd[1]) begin
        errors++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.p0_rdata, bus.p1_rdata, erd[0], erd[1]); end
      g   = model_grant(pend[0], pend[1]);
      bad = (g >= 0) ? addr_bad(ad[g]) : 1'b0;
      checks++; if ({bus.p0_gnt, bus.p1_gnt} !== {g == 0, g == 1}) begin
        errors++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, {bus.p0_gnt, bus.p1_gnt}, {g == 0, g == 1}); end
      checks++; if ({bus.mem_read, bus.mem_write} !== {g >= 0 && !we[g] && !bad, g >= 0 && we[g] && !bad}) begin
        errors++; $display("FAIL rnd_mem cyc=%0d got=%b exp=%b", cyc, {bus.mem_read, bus.mem_write},
          {g >= 0 && !we[g] && !bad, g >= 0 && we[g] && !bad}); end
      for (int p = 0; p < 2; p++) begin
        erv[p] = 0; eerr[p] = 0; erd[p] = 0;
      end
      if (g >= 0) begin
        erv[g]  = 1;
        eerr[g] = bad;
        erd[g]  = (bad || we[g]) ? 32'h0 : exp_mem[ad[g][9:2]];
        if (!bad && we[g]) exp_mem[ad[g][9:2]] = wd[g];
      end
      own = m_locked ? lk_in[m_owner] : 1'b0;
      model_advance(g, (g >= 0) ? lk_in[g] : 1'b0, bad, own);
      last_g = g;
      @(posedge clk); #1;
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    test_reset();
    test_write_read();
    test_alternate();
    test_errors();
    test_lock_rmw();
    test_lock_timeout();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
